apb_slave_regfile: RTL and testbench

APB responder sitting on the far side of the AHB-to-APB bridge: it decodes one bit of the bridge's one-hot `Pselx` bus and serves APB setup/access transfers into a small peripheral register block. The register block holds 4 scratch registers, a control register, a free-running event counter, a write-transaction counter and a read-only ID. The block adds optional wait states via `Pready` and reports decode/permission errors via `Pslverr`, so the bridge's APB master side can be exercised against a real sequential slave.

---
 rtl/apb_slave_regfile.sv | 151 +++++++++++++++
 tb/tb_apb_slave_regfile.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB responder with scratch, control, counter and ID registers
module apb_slave_regfile #(
    parameter int unsigned SLV_ID      = 0,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic [2:0]  Pselx,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
    output logic        Pready,
    output logic        Pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP_SEEN, ACCESS} state_t;

    state_t           state_q, state_d;
    logic [7:0]       addr_q, addr_d;
    logic             write_q, write_d;
    logic [3:0]       wait_q, wait_d;
    logic [31:0]      prdata_q, prdata_d;
    logic [3:0][31:0] regs_q, regs_d;
    logic             cnt_en_q, cnt_en_d;
    logic [31:0]      count_q, count_d;
    logic [15:0]      wcnt_q, wcnt_d;

    logic        sel;
    logic        in_access;
    logic        violation;
    logic        complete;
    logic        addr_err;
    logic        wr_err;
    logic        commit;
    logic        cnt_clr;
    logic [31:0] rd_mux;
    logic        unused_paddr;

    assign sel          = Pselx[SLV_ID];
    assign in_access    = (state_q == SETUP_SEEN) || (state_q == ACCESS);
    assign violation    = (state_q == IDLE) && sel && Penable;
    assign complete     = in_access && (wait_q == 4'd0) && sel && Penable;
    assign addr_err     = (addr_q[1:0] != 2'b00) || (addr_q[7:5] != 3'b000);
    // COUNT (0x14), WCNT (0x18) and ID (0x1C) are the read-only slots
    assign wr_err       = write_q && addr_q[4] && (addr_q[3:2] != 2'b00);
    assign commit       = complete && write_q && !addr_err && !wr_err;
    assign unused_paddr = ^Paddr[31:8];

    assign Prdata  = prdata_q;
    assign Pready  = in_access ? (wait_q == 4'd0) : violation;
    assign Pslverr = violation || (complete && (addr_err || wr_err));

    // Read mux on the live setup address; bad addresses read as zero
    always_comb begin
        rd_mux = '0;
        if ((Paddr[1:0] == 2'b00) && (Paddr[7:5] == 3'b000)) begin
            case (Paddr[4:2])
                3'd4:    rd_mux = {31'b0, cnt_en_q};
                3'd5:    rd_mux = count_q;
                3'd6:    rd_mux = {16'b0, wcnt_q};
                3'd7:    rd_mux = ID_VALUE;
                default: rd_mux = regs_q[Paddr[3:2]];
            endcase
        end
    end

    // Transfer FSM: capture on setup, count down wait states, finish or abort
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        write_d  = write_q;
        wait_d   = wait_q;
        prdata_d = prdata_q;
        case (state_q)
            IDLE: begin
                if (sel && !Penable) begin
                    state_d  = SETUP_SEEN;
                    addr_d   = Paddr[7:0];
                    write_d  = Pwrite;
                    wait_d   = 4'(WAIT_STATES);
                    prdata_d = rd_mux;
                end
            end
            SETUP_SEEN, ACCESS: begin
                if (!sel || complete) begin
                    state_d = IDLE;
                    wait_d  = 4'd0;
                end else begin
                    state_d = ACCESS;
                    if (wait_q != 4'd0) begin
                        wait_d = wait_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register block: commit writes on the completing cycle, run the counters
    always_comb begin
        regs_d   = regs_q;
        cnt_en_d = cnt_en_q;
        wcnt_d   = wcnt_q;
        cnt_clr  = 1'b0;
        if (commit) begin
            wcnt_d = wcnt_q + 16'd1;
            if (!addr_q[4]) begin
                regs_d[addr_q[3:2]] = Pwdata;
            end else if (addr_q[3:2] == 2'b00) begin
                cnt_en_d = Pwdata[0];
                cnt_clr  = Pwdata[1];
            end
        end
        if (cnt_clr) begin
            count_d = '0;
        end else if (cnt_en_q) begin
            count_d = count_q + 32'd1;
        end else begin
            count_d = count_q;
        end
    end

    // State and register flops
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wait_q   <= '0;
            prdata_q <= '0;
            regs_q   <= '0;
            cnt_en_q <= 1'b0;
            count_q  <= '0;
            wcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            wait_q   <= wait_d;
            prdata_q <= prdata_d;
            regs_q   <= regs_d;
            cnt_en_q <= cnt_en_d;
            count_q  <= count_d;
            wcnt_q   <= wcnt_d;
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb/tb_apb_slave_regfile.sv - directed bench for apb_slave_regfile
module tb_apb_slave_regfile;

    logic        Hclk = 1'b0;
    logic        Hresetn;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] prdata_v [3];
    logic [2:0]  pready_v;
    logic [2:0]  pslverr_v;

    int tests = 0;
    int fails = 0;

    always #5 Hclk = ~Hclk;

    apb_slave_regfile #(.SLV_ID(0), .WAIT_STATES(0)) u_s0 (
        .Hclk(Hclk), .Hresetn(Hresetn), .Pselx(Pselx), .Penable(Penable),
        .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
        .Prdata(prdata_v[0]), .Pready(pready_v[0]), .Pslverr(pslverr_v[0]));

    apb_slave_regfile #(.SLV_ID(1), .WAIT_STATES(3)) u_s1 (
        .Hclk(Hclk), .Hresetn(Hresetn), .Pselx(Pselx), .Penable(Penable),
        .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
        .Prdata(prdata_v[1]), .Pready(pready_v[1]), .Pslverr(pslverr_v[1]));

    apb_slave_regfile #(.SLV_ID(2), .WAIT_STATES(2)) u_s2 (
        .Hclk(Hclk), .Hresetn(Hresetn), .Pselx(Pselx), .Penable(Penable),
        .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
        .Prdata(prdata_v[2]), .Pready(pready_v[2]), .Pslverr(pslverr_v[2]));

    // Called at posedge+1; returns at posedge+1 after the completing edge
    task automatic apb_xfer(input int s, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata,
                            output logic err, output int waits);
        int n;
        Pselx   = 3'b001 << s;
        Penable = 1'b0;
        Pwrite  = wr;
        Paddr   = addr;
        Pwdata  = wdata;
        @(posedge Hclk); #1;
        Penable = 1'b1;
        waits   = 0;
        for (n = 0; n < 40; n++) begin
            @(negedge Hclk);
            if (pready_v[s]) break;
            waits++;
            @(posedge Hclk); #1;
        end
        if (n == 40) begin
            tests++;
            fails++;
            $display("FAIL timeout slave %0d addr %h: Pready never rose", s, addr);
        end
        err   = pslverr_v[s];
        rdata = prdata_v[s];
        @(posedge Hclk); #1;
        Pselx   = 3'b000;
        Penable = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic        err;
        int          w;
        tests++;
        if (pready_v !== 3'b000 || pslverr_v !== 3'b000 || prdata_v[0] !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs: pready=%b pslverr=%b prdata=%h, need 0", pready_v, pslverr_v, prdata_v[0]);
        end
        Hresetn = 1'b1;
        @(posedge Hclk); #1;
        for (int a = 0; a < 7; a++) begin
            apb_xfer(0, 1'b0, 32'(a * 4), 32'h0, rd, err, w);
            tests++;
            if (rd !== 32'h0 || err !== 1'b0) begin
                fails++;
                $display("FAIL reset_reg %h: got %h err %b, need 0 err 0", a * 4, rd, err);
            end
        end
        apb_xfer(0, 1'b0, 32'h1C, 32'h0, rd, err, w);
        tests++;
        if (rd !== 32'hA5B0_0001) begin
            fails++;
            $display("FAIL reset_id: got %h, need a5b00001", rd);
        end
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        logic        err;
        int          w;
        apb_xfer(0, 1'b1, 32'h04, 32'hDEADBEEF, rd, err, w);
        tests++;
        if (w !== 0 || err !== 1'b0) begin
            fails++;
            $display("FAIL basic_write: waits %0d err %b, need 0 0", w, err);
        end
        apb_xfer(0, 1'b0, 32'h04, 32'h0, rd, err, w);
        tests++;
        if (rd !== 32'hDEADBEEF || err !== 1'b0 || w !== 0) begin
            fails++;
            $display("FAIL basic_read: got %h err %b waits %0d, need deadbeef 0 0", rd, err, w);
        end
        apb_xfer(0, 1'b0, 32'h18, 32'h0, rd, err, w);
        tests++;
        if (rd !== 32'd1) begin
            fails++;
            $display("FAIL basic_wcnt: got %h, need 1", rd);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd;
        logic        err;
        int          w;
        apb_xfer(1, 1'b1, 32'h00, 32'h12345678, rd, err, w);
        tests++;
        if (w !== 3 || err !== 1'b0) begin
            fails++;
            $display("FAIL wait_write: waits %0d err %b, need 3 0", w, err);
        end
        apb_xfer(1, 1'b0, 32'h00, 32'h0, rd, err, w);
        tests++;
        if (rd !== 32'h12345678 || w !== 3) begin
            fails++;
            $display("FAIL wait_read: got %h waits %0d, need 12345678 3", rd, w);
        end
        // Abort a write before it completes: nothing may land
        Pselx = 3'b010; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h04; Pwdata = 32'hFFFFFFFF;
        @(posedge Hclk); #1;
        Penable = 1'b1;
        @(negedge Hclk);
        tests++;
        if (pready_v[1] !== 1'b0) begin
            fails++;
            $display("FAIL wait_first_access: pready %b, need 0", pready_v[1]);
        end
        @(posedge Hclk); #1;
        Pselx = 3'b000; Penable = 1'b0;
        @(posedge Hclk); #1;
        apb_xfer(1, 1'b0, 32'h04, 32'h0, rd, err, w);
        tests++;
        if (rd !== 32'h0) begin
            fails++;
            $display("FAIL abort_no_commit: got %h, need 0", rd);
        end
        apb_xfer(1, 1'b0, 32'h18, 32'h0, rd, err, w);
        tests++;
        if (rd !== 32'd1) begin
            fails++;
            $display("FAIL abort_wcnt: got %h, need 1", rd);
        end
    endtask

    task automatic test_counter();
        logic [31:0] rd;
        logic        err;
        int          w;
        apb_xfer(0, 1'b1, 32'h10, 32'h1, rd, err, w);
        repeat (10) @(posedge Hclk);
        #1;
        apb_xfer(0, 1'b0, 32'h14, 32'h0, rd, err, w);
        tests++;
        if (rd !== 32'd10) begin
            fails++;
            $display("FAIL count_run: got %0d, need 10", rd);
        end
        apb_xfer(0, 1'b1, 32'h10, 32'h2, rd, err, w);
        apb_xfer(0, 1'b0, 32'h14, 32'h0, rd, err, w);
        tests++;
        if (rd !== 32'd0) begin
            fails++;
            $display("FAIL count_clear: got %0d, need 0", rd);
        end
        apb_xfer(0, 1'b0, 32'h14, 32'h0, rd, err, w);
        tests++;
        if (rd !== 32'd0) begin
            fails++;
            $display("FAIL count_stays: got %0d, need 0", rd);
        end
        apb_xfer(0, 1'b0, 32'h10, 32'h0, rd, err, w);
        tests++;
        if (rd !== 32'd0) begin
            fails++;
            $display("FAIL ctrl_after_clear: got %h, need 0", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        err;
        int          w;
        apb_xfer(0, 1'b1, 32'h1C, 32'h1, rd, err, w);
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL err_write_id: pslverr %b, need 1", err);
        end
        apb_xfer(0, 1'b1, 32'h20, 32'h5, rd, err, w);
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL err_write_oob: pslverr %b, need 1", err);
        end
        apb_xfer(0, 1'b0, 32'h05, 32'h0, rd, err, w);
        tests++;
        if (err !== 1'b1 || rd !== 32'h0) begin
            fails++;
            $display("FAIL err_read_unaligned: pslverr %b data %h, need 1 0", err, rd);
        end
        apb_xfer(0, 1'b0, 32'h1C, 32'h0, rd, err, w);
        tests++;
        if (rd !== 32'hA5B0_0001 || err !== 1'b0) begin
            fails++;
            $display("FAIL err_id_intact: got %h err %b, need a5b00001 0", rd, err);
        end
        apb_xfer(0, 1'b0, 32'h18, 32'h0, rd, err, w);
        tests++;
        if (rd !== 32'd3) begin
            fails++;
            $display("FAIL err_wcnt: got %0d, need 3", rd);
        end
    endtask

    task automatic test_violation();
        logic [31:0] rd;
        logic        err;
        int          w;
        Pselx = 3'b001; Penable = 1'b1; Pwrite = 1'b1; Paddr = 32'h00; Pwdata = 32'hBAD0BAD0;
        @(negedge Hclk);
        tests++;
        if (pready_v !== 3'b001 || pslverr_v !== 3'b001) begin
            fails++;
            $display("FAIL violation: pready %b pslverr %b, need 001 001", pready_v, pslverr_v);
        end
        @(posedge Hclk); #1;
        Pselx = 3'b000; Penable = 1'b0;
        @(negedge Hclk);
        tests++;
        if (pready_v[0] !== 1'b0 || pslverr_v[0] !== 1'b0) begin
            fails++;
            $display("FAIL violation_one_cycle: pready %b pslverr %b, need 0 0", pready_v[0], pslverr_v[0]);
        end
        @(posedge Hclk); #1;
        apb_xfer(0, 1'b0, 32'h00, 32'h0, rd, err, w);
        tests++;
        if (rd !== 32'h0) begin
            fails++;
            $display("FAIL violation_no_commit: got %h, need 0", rd);
        end
        // Transfer aimed at slave 2 must leave slave 0 silent
        Pselx = 3'b100; Penable = 1'b0; Pwrite = 1'b0; Paddr = 32'h00;
        @(posedge Hclk); #1;
        Penable = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge Hclk);
            tests++;
            if (pready_v[0] !== 1'b0 || pready_v[2] !== (c == 2)) begin
                fails++;
                $display("FAIL other_select c%0d: pready %b, need s0=0 s2=%0d", c, pready_v, c == 2);
            end
            @(posedge Hclk); #1;
        end
        Pselx = 3'b000; Penable = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic        err;
        int          w;
        int          wsum;
        wsum = 0;
        apb_xfer(0, 1'b1, 32'h00, 32'h11111111, rd, err, w); wsum += w;
        apb_xfer(0, 1'b1, 32'h08, 32'h22222222, rd, err, w); wsum += w;
        apb_xfer(0, 1'b0, 32'h00, 32'h0, rd, err, w);        wsum += w;
        tests++;
        if (rd !== 32'h11111111) begin
            fails++;
            $display("FAIL b2b_reg0: got %h, need 11111111", rd);
        end
        apb_xfer(0, 1'b0, 32'h08, 32'h0, rd, err, w);        wsum += w;
        tests++;
        if (rd !== 32'h22222222 || wsum !== 0) begin
            fails++;
            $display("FAIL b2b_reg2: got %h waits %0d, need 22222222 0", rd, wsum);
        end
        apb_xfer(0, 1'b0, 32'h18, 32'h0, rd, err, w);
        tests++;
        if (rd !== 32'd5) begin
            fails++;
            $display("FAIL b2b_wcnt: got %0d, need 5", rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        err;
        int          w;
        apb_xfer(2, 1'b1, 32'h0C, 32'h77, rd, err, w);
        Pselx = 3'b100; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h0C; Pwdata = 32'h55;
        @(posedge Hclk); #1;
        Penable = 1'b1;
        @(negedge Hclk); @(posedge Hclk); #1;
        @(negedge Hclk); @(posedge Hclk); #1;
        @(negedge Hclk);
        tests++;
        if (pready_v[2] !== 1'b1 || prdata_v[2] !== 32'h77) begin
            fails++;
            $display("FAIL mid_pre_reset: pready %b prdata %h, need 1 77", pready_v[2], prdata_v[2]);
        end
        #2;
        Hresetn = 1'b0; Pselx = 3'b000; Penable = 1'b0;
        #1;
        tests++;
        if (pready_v !== 3'b000 || pslverr_v !== 3'b000 ||
            prdata_v[0] !== 32'h0 || prdata_v[1] !== 32'h0 || prdata_v[2] !== 32'h0) begin
            fails++;
            $display("FAIL mid_reset_outputs: pready %b pslverr %b prdata %h %h %h, need 0",
                     pready_v, pslverr_v, prdata_v[0], prdata_v[1], prdata_v[2]);
        end
        @(posedge Hclk); #3;
        Hresetn = 1'b1;
        @(posedge Hclk); #1;
        apb_xfer(2, 1'b0, 32'h0C, 32'h0, rd, err, w);
        tests++;
        if (rd !== 32'h0) begin
            fails++;
            $display("FAIL mid_reset_reg: got %h, need 0", rd);
        end
        apb_xfer(0, 1'b0, 32'h04, 32'h0, rd, err, w);
        tests++;
        if (rd !== 32'h0) begin
            fails++;
            $display("FAIL mid_reset_s0: got %h, need 0", rd);
        end
    endtask

    initial begin
        Hresetn = 1'b0;
        Pselx   = 3'b000;
        Penable = 1'b0;
        Pwrite  = 1'b0;
        Paddr   = 32'h0;
        Pwdata  = 32'h0;
        repeat (3) @(posedge Hclk);
        #1;
        test_reset();
        test_basic();
        test_wait_states();
        test_counter();
        test_errors();
        test_violation();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
